// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Program counter and instruction register stage. Applies the
//                Controller's PC commands and fetches one opcode per LoadIR
//                over a req/ack handshake, with a bounded wait that forces a
//                HALT opcode and a sticky error on timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                     PC_WIDTH    = 8,
    parameter int                     INSTR_WIDTH = 8,
    parameter int                     TIMEOUT     = 15,
    parameter logic [INSTR_WIDTH-1:0] HALT_OP     = 8'hF0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   LoadIR,
    input  logic                   IncPC,
    input  logic                   LoadPC,
    input  logic                   SelPC,
    input  logic [PC_WIDTH-1:0]    RegData,
    input  logic [3:0]             ImmediateData,
    output logic                   mem_req,
    output logic [PC_WIDTH-1:0]    mem_addr,
    input  logic                   mem_ack,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    output logic [INSTR_WIDTH-1:0] Opcode,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   ir_valid,
    output logic                   busy,
    output logic                   fetch_err
);

    localparam int                   CNT_W      = $clog2(TIMEOUT + 1);
    // Last count value before the timeout fires; the edge that would make the
    // counter equal TIMEOUT is the edge that raises the error instead.
    localparam logic [CNT_W-1:0]     c_CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]     c_CNT_ONE  = CNT_W'(1);
    localparam logic [PC_WIDTH-1:0]  c_PC_ONE   = PC_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t                   r_state, w_state_nxt;
    logic [PC_WIDTH-1:0]      r_pc, w_pc_nxt;
    logic [PC_WIDTH-1:0]      r_addr, w_addr_nxt;
    logic                     r_req, w_req_nxt;
    logic                     r_busy, w_busy_nxt;
    logic                     r_valid, w_valid_nxt;
    logic [INSTR_WIDTH-1:0]   r_op, w_op_nxt;
    logic                     r_err, w_err_nxt;
    logic [CNT_W-1:0]         r_cnt, w_cnt_nxt;
    logic [PC_WIDTH-1:0]      w_imm_ext;

    assign w_imm_ext = {{(PC_WIDTH-4){1'b0}}, ImmediateData};

    // Next-state, PC update and handshake/IR next values; everything holds by default.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_addr_nxt  = r_addr;
        w_req_nxt   = r_req;
        w_busy_nxt  = r_busy;
        w_valid_nxt = r_valid;
        w_op_nxt    = r_op;
        w_err_nxt   = r_err;
        w_cnt_nxt   = r_cnt;

        // PC commands run independently of the fetch; the in-flight address
        // lives in r_addr so a mid-fetch jump cannot disturb it.
        if (r_state != S_ERR) begin
            if (LoadPC) begin
                w_pc_nxt = SelPC ? w_imm_ext : RegData;
            end else if (IncPC) begin
                w_pc_nxt = r_pc + c_PC_ONE;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (LoadIR) begin
                    // Captures the pre-update PC even if IncPC/LoadPC fire on this edge.
                    w_addr_nxt  = r_pc;
                    w_req_nxt   = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_valid_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    w_op_nxt    = mem_rdata;
                    w_valid_nxt = 1'b1;
                    w_req_nxt   = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_op_nxt    = HALT_OP;
                    w_valid_nxt = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_req_nxt   = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_ERR;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            S_ERR: begin
                w_req_nxt  = 1'b0;
                w_busy_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; active-low synchronous reset overrides all.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_addr  <= '0;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_op    <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_addr  <= w_addr_nxt;
            r_req   <= w_req_nxt;
            r_busy  <= w_busy_nxt;
            r_valid <= w_valid_nxt;
            r_op    <= w_op_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign mem_req   = r_req;
    assign mem_addr  = r_addr;
    assign Opcode    = r_op;
    assign pc        = r_pc;
    assign ir_valid  = r_valid;
    assign busy      = r_busy;
    assign fetch_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed, table-driven bench for fetch_unit with hand-written
//                sequences for wait states, timeout and reset recovery.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic       clk;
    logic       reset;
    logic       LoadIR, IncPC, LoadPC, SelPC;
    logic [7:0] RegData;
    logic [3:0] ImmediateData;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic [7:0] Opcode;
    logic [7:0] pc;
    logic       ir_valid, busy, fetch_err;

    // ack_mode: 0 = ack low, 1 = ack forced high, 2 = ack tied to mem_req
    logic [1:0] ack_mode;
    logic [7:0] mem [256];

    int n_checks = 0;
    int n_errors = 0;

    assign mem_ack   = (ack_mode == 2'd2) ? mem_req : (ack_mode == 2'd1);
    assign mem_rdata = mem[mem_addr];

    fetch_unit #(
        .PC_WIDTH    (8),
        .INSTR_WIDTH (8),
        .TIMEOUT     (15),
        .HALT_OP     (8'hF0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .LoadIR        (LoadIR),
        .IncPC         (IncPC),
        .LoadPC        (LoadPC),
        .SelPC         (SelPC),
        .RegData       (RegData),
        .ImmediateData (ImmediateData),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .Opcode        (Opcode),
        .pc            (pc),
        .ir_valid      (ir_valid),
        .busy          (busy),
        .fetch_err     (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       lir, inc, ldpc, sel;
        logic [7:0] rd;
        logic [3:0] imm;
        logic [1:0] ack;
        logic [7:0] e_pc, e_op;
        logic       e_v, e_req;
        logic [7:0] e_addr;
        logic       e_busy, e_err;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] e_pc, input logic [7:0] e_op,
                           input logic e_v, input logic e_req, input logic [7:0] e_addr,
                           input logic e_busy, input logic e_err);
        chk({tag, ".pc"},        32'(pc),        32'(e_pc));
        chk({tag, ".Opcode"},    32'(Opcode),    32'(e_op));
        chk({tag, ".ir_valid"},  32'(ir_valid),  32'(e_v));
        chk({tag, ".mem_req"},   32'(mem_req),   32'(e_req));
        chk({tag, ".mem_addr"},  32'(mem_addr),  32'(e_addr));
        chk({tag, ".busy"},      32'(busy),      32'(e_busy));
        chk({tag, ".fetch_err"}, 32'(fetch_err), 32'(e_err));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic lir, input logic inc, input logic ldpc,
                         input logic sel, input logic [7:0] rd, input logic [3:0] imm,
                         input logic [1:0] ack);
        reset = r; LoadIR = lir; IncPC = inc; LoadPC = ldpc; SelPC = sel;
        RegData = rd; ImmediateData = imm; ack_mode = ack;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[0] = 8'hD5;
        mem[7] = 8'h3E;

        //          rst lir inc ld sel rd     imm   ack    pc     op     v  req addr  bsy err
        vecs[0]  = '{0, 1, 1, 0, 0, 8'h00, 4'h0, 2'd1, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0};
        vecs[1]  = '{0, 1, 1, 0, 0, 8'h00, 4'h0, 2'd1, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0};
        vecs[2]  = '{1, 0, 0, 0, 0, 8'h00, 4'h0, 2'd2, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0};
        vecs[3]  = '{1, 1, 0, 0, 0, 8'h00, 4'h0, 2'd2, 8'h00, 8'h00, 0, 1, 8'h00, 1, 0};
        vecs[4]  = '{1, 0, 0, 0, 0, 8'h00, 4'h0, 2'd2, 8'h00, 8'hD5, 1, 0, 8'h00, 0, 0};
        vecs[5]  = '{1, 0, 0, 0, 0, 8'h00, 4'h0, 2'd2, 8'h00, 8'hD5, 1, 0, 8'h00, 0, 0};
        vecs[6]  = '{1, 0, 0, 1, 0, 8'h3C, 4'h0, 2'd2, 8'h3C, 8'hD5, 1, 0, 8'h00, 0, 0};
        vecs[7]  = '{1, 0, 1, 1, 1, 8'h3C, 4'hA, 2'd2, 8'h0A, 8'hD5, 1, 0, 8'h00, 0, 0};
        vecs[8]  = '{1, 0, 0, 1, 0, 8'hFF, 4'h0, 2'd2, 8'hFF, 8'hD5, 1, 0, 8'h00, 0, 0};
        vecs[9]  = '{1, 0, 1, 0, 0, 8'h00, 4'h0, 2'd2, 8'h00, 8'hD5, 1, 0, 8'h00, 0, 0};
        vecs[10] = '{1, 0, 0, 1, 0, 8'h07, 4'h0, 2'd2, 8'h07, 8'hD5, 1, 0, 8'h00, 0, 0};
        vecs[11] = '{1, 1, 1, 0, 0, 8'h00, 4'h0, 2'd2, 8'h08, 8'hD5, 0, 1, 8'h07, 1, 0};
        vecs[12] = '{1, 0, 0, 0, 0, 8'h00, 4'h0, 2'd2, 8'h08, 8'h3E, 1, 0, 8'h07, 0, 0};
        vecs[13] = '{1, 0, 0, 0, 0, 8'h00, 4'h0, 2'd1, 8'h08, 8'h3E, 1, 0, 8'h07, 0, 0};

        // Reset, zero-wait fetch, jumps, wrap and fetch with PC update on the same edge
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].rst_n, vecs[i].lir, vecs[i].inc, vecs[i].ldpc, vecs[i].sel,
                  vecs[i].rd, vecs[i].imm, vecs[i].ack);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_op, vecs[i].e_v,
                    vecs[i].e_req, vecs[i].e_addr, vecs[i].e_busy, vecs[i].e_err);
        end

        // Wait states with a PC increment and an ignored LoadIR mid-fetch
        drive(1, 0, 0, 1, 0, 8'h00, 4'h0, 2'd0);
        step();
        chk("t3.jump0.pc", 32'(pc), 32'h00);
        drive(1, 1, 0, 0, 0, 8'h00, 4'h0, 2'd0);
        step();
        chk_all("t3.start", 8'h00, 8'h3E, 0, 1, 8'h00, 1, 0);
        drive(1, 1, 1, 0, 0, 8'h00, 4'h0, 2'd0);
        step();
        chk_all("t3.inc", 8'h01, 8'h3E, 0, 1, 8'h00, 1, 0);
        drive(1, 0, 0, 0, 0, 8'h00, 4'h0, 2'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("t3.wait%0d.mem_req", k), 32'(mem_req), 32'h1);
            chk($sformatf("t3.wait%0d.mem_addr", k), 32'(mem_addr), 32'h00);
        end
        ack_mode = 2'd1;
        step();
        chk_all("t3.ack", 8'h01, 8'hD5, 1, 0, 8'h00, 0, 0);
        ack_mode = 2'd0;
        step();
        chk_all("t3.after", 8'h01, 8'hD5, 1, 0, 8'h00, 0, 0);

        // Timeout: 15 unanswered cycles, then terminal ERR
        drive(1, 1, 0, 0, 0, 8'h00, 4'h0, 2'd0);
        step();
        chk_all("t6.start", 8'h01, 8'hD5, 0, 1, 8'h01, 1, 0);
        LoadIR = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            step();
            chk($sformatf("t6.wait%0d.mem_req", k), 32'(mem_req), 32'h1);
            chk($sformatf("t6.wait%0d.fetch_err", k), 32'(fetch_err), 32'h0);
        end
        step();
        chk_all("t6.timeout", 8'h01, 8'hF0, 1, 0, 8'h01, 0, 1);
        drive(1, 1, 1, 1, 0, 8'h55, 4'h0, 2'd1);
        for (int k = 0; k < 2; k++) begin
            step();
            chk_all($sformatf("t6.err%0d", k), 8'h01, 8'hF0, 1, 0, 8'h01, 0, 1);
        end
        reset = 1'b0;
        step();
        chk_all("t6.reset", 8'h00, 8'h00, 0, 0, 8'h00, 0, 0);

        // Recovery: a normal zero-wait fetch works again after reset
        drive(1, 1, 0, 0, 0, 8'h00, 4'h0, 2'd2);
        step();
        LoadIR = 1'b0;
        step();
        chk_all("t6.recover", 8'h00, 8'hD5, 1, 0, 8'h00, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
